// File: rtl/wb_writer.sv
// wb_writer: write-back stage, writer side of the CPU register file.
//
// ALU results from the EX/MEM boundary are written to the register file one
// cycle after acceptance. Loads issue a word-aligned read to data memory, then
// align and extend the returned word (RV32I LB/LH/LW/LBU/LHU) and write it back.
// The stage stalls upstream (ex_ready=0) while a load is in flight.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   ex_valid/ready   upstream instruction handshake
//   ex_wreg, ex_wd   instruction writes rd / rd index
//   ex_wdata         ALU result, or effective address for loads
//   ex_load          instruction is a load
//   ex_funct3        load type
//   mem_req_*        data memory read request (valid/ready, word address)
//   mem_resp_*       data memory read response
//   we/waddr/wdata   register file write port
//   load_err         one-cycle pulse on a misaligned or illegal load
//   busy             load in flight
//
// State | meaning
// IDLE  | ready for a new instruction
// REQ   | read request presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_resp_valid

module wb_writer #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic              ex_load,
    input  logic [2:0]        ex_funct3,
    output logic              mem_req_valid,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    output logic              load_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [REG_AW-1:0] r_rd;
    logic              r_wreg;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;

    logic              w_accept;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_load_bad;
    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_ext;

    assign ex_ready      = (r_state == S_IDLE);
    assign busy          = !ex_ready;
    assign mem_req_valid = (r_state == S_REQ);
    assign w_accept      = ex_valid & ex_ready;

    always_comb begin
        w_misalign = 1'b0;
        w_illegal  = 1'b0;
        case (ex_funct3)
            3'b000, 3'b100: w_misalign = 1'b0;
            3'b001, 3'b101: w_misalign = ex_wdata[0];
            3'b010:         w_misalign = (ex_wdata[1:0] != 2'b00);
            default:        w_illegal  = 1'b1;
        endcase
    end

    assign w_load_bad = w_misalign | w_illegal;

    // Bring the addressed byte/half down to bit 0, then extend by load type.
    assign w_shift = mem_resp_data >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shift;
        case (r_funct3)
            3'b000:  w_ext = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_shift[7:0]};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && ex_load && !w_load_bad) w_next = S_REQ;
            S_REQ:   if (mem_req_ready) w_next = S_WAIT;
            S_WAIT:  if (mem_resp_valid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            load_err     <= 1'b0;
            mem_req_addr <= '0;
            r_rd         <= '0;
            r_wreg       <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
        end else begin
            we       <= 1'b0;
            load_err <= 1'b0;
            if (w_accept) begin
                if (!ex_load) begin
                    we    <= ex_wreg & (ex_wd != '0);
                    waddr <= ex_wd;
                    wdata <= ex_wdata;
                end else if (w_load_bad) begin
                    load_err <= 1'b1;
                end else begin
                    r_rd         <= ex_wd;
                    r_wreg       <= ex_wreg;
                    r_funct3     <= ex_funct3;
                    r_off        <= ex_wdata[1:0];
                    mem_req_addr <= {ex_wdata[XLEN-1:2], 2'b00};
                end
            end
            // Responses outside WAIT are stale or unsolicited and are dropped.
            if (r_state == S_WAIT && mem_resp_valid) begin
                we    <= r_wreg & (r_rd != '0);
                waddr <= r_rd;
                wdata <= w_ext;
            end
        end
    end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back stage: the writer side of the CPU register file interface.
- Takes completed instructions from the EX/MEM boundary and drives the register-file write port (we/waddr/wdata).
- ALU results pass through with one-cycle latency.
- Loads issue a word request to data memory, align and extend the returned data per RV32I funct3, and stall the upstream pipeline until write-back.

Parameters:
- XLEN, 32, data/address width.
- REG_AW, 5, register address width; 2**REG_AW registers, x0 hardwired zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  upstream instruction valid
- ex_ready  out  1  stage accepts instruction this cycle
- ex_wreg  in  1  instruction writes rd
- ex_wd  in  REG_AW  rd index
- ex_wdata  in  XLEN  ALU result, or effective address when ex_load=1
- ex_load  in  1  instruction is a load
- ex_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_req_valid  out  1  read request valid
- mem_req_addr  out  XLEN  word-aligned read address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data valid
- mem_resp_data  in  XLEN  read word
- we  out  1  regfile write enable
- waddr  out  REG_AW  regfile write address
- wdata  out  XLEN  regfile write data
- load_err  out  1  one-cycle pulse: misaligned or illegal load
- busy  out  1  load in flight (state != IDLE)

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - we, waddr, wdata, load_err, mem_req_valid, mem_req_addr all 0.
  - Any in-flight request is abandoned; a later mem_resp_valid is ignored.
- States: IDLE, REQ, WAIT. ex_ready = (state==IDLE). busy = !ex_ready.
- IDLE, accept = ex_valid & ex_ready:
  - Non-load: next cycle we = ex_wreg & (ex_wd!=0), waddr = ex_wd, wdata = ex_wdata. We is a one-cycle pulse, so back-to-back non-loads give one write per cycle.
  - Load: capture rd, wreg, funct3, addr[1:0]. Check the load first:
    - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
    - Illegal: funct3 in {011,110,111}.
    - Either case: next cycle load_err=1, we=0, no request, stay IDLE.
    - Otherwise: go to REQ; mem_req_addr = {addr[XLEN-1:2],2'b00} is registered.
- REQ:
  - mem_req_valid=1; mem_req_addr held stable until handshake.
  - On mem_req_ready: mem_req_valid drops the next cycle; go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - mem_resp_valid in REQ or IDLE is ignored; responses arrive at least one cycle after the request handshake.
  - On mem_resp_valid, select byte/half by the captured addr[1:0]:
    - LB/LH: sign-extend.
    - LBU/LHU: zero-extend.
    - LW: whole word.
  - Next cycle: we = wreg & (rd!=0), waddr = rd, wdata = extended value; state returns to IDLE in that same cycle. A new instruction may be accepted in the cycle we is high.
- Load to x0: the request is still issued and the response consumed; we stays 0.
- Non-write cycles: we=0; waddr/wdata hold their last value (don't-care to the regfile).
- Latency:
  - ALU op: 1 cycle from accept to we.
  - Load: accept → REQ (1) → handshake → WAIT → resp → we (+1).
- Reset in REQ/WAIT: returns to IDLE, no write, mem_req_valid deasserts the next cycle.

Test Plan:
- ALU passthrough: ex_valid, wreg=1, wd=5, wdata=0xDEADBEEF, load=0 → next cycle we=1, waddr=5, wdata=0xDEADBEEF. Back-to-back wd=6/wd=7 give consecutive write pulses. wd=0 gives we=0.
- LB sign-extend: addr=0x1003, funct3=000, wd=3:
  - Expect mem_req_addr=0x1000.
  - Hold mem_req_ready=0 for 3 cycles; request must stay stable.
  - Resp 0x80FFFFFF → we=1, waddr=3, wdata=0xFFFFFF80.
  - ex_ready=0 throughout the load.
- LHU/LH at addr 0x2002, resp 0x8001_1234:
  - LHU → wdata=0x00008001.
  - LH → 0xFFFF8001.
  - LW at 0x2000 → 0x80011234.
- Misaligned/illegal:
  - LW addr=0x3001 → load_err pulse, mem_req_valid never asserted, we=0, ex_ready stays 1.
  - funct3=011 → same response.
- Load to x0: wd=0, LW → request issued and response consumed, we stays 0, state returns to IDLE.
- Reset mid-load: assert rst in WAIT → next cycle IDLE, all outputs 0. A mem_resp_valid arriving afterwards produces no write.
